// File: rtl/mc_stream_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_stream_host_pkg
// Description : Shared types, default addresses and helpers for the manycore
//               host-stream dispatch front end.
// Contents    : fence_state_e  - fence sequencer states
//               NBF_ADDR / MMIO_ADDR / FENCE_ADDR - default stream addresses
//               chan_addr()    - address of sink channel k
//               safe_clog2()   - ceil(log2(x)), never below 1
// Revision    : 1.0 - initial release
// ============================================================================
package mc_stream_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DRAIN_FIFO = 2'd1,
        ST_DRAIN_CRED = 2'd2
    } fence_state_e;

    localparam logic [31:0] NBF_ADDR   = 32'h10;
    localparam logic [31:0] MMIO_ADDR  = 32'h20;
    localparam logic [31:0] FENCE_ADDR = 32'h100;

    // Computed at 64 bits; callers truncate to their address width, which
    // gives the wrap-around behaviour at that width.
    function automatic logic [63:0] chan_addr(input int unsigned base,
                                              input int unsigned stride,
                                              input int unsigned k);
        return 64'(base) + 64'(k) * 64'(stride);
    endfunction

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage : mc_stream_host_pkg
`default_nettype wire

// File: rtl/mc_stream_host_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mc_stream_host_dispatch_fifo
// Description : Small 1-read/1-write FIFO used as the per-channel sink buffer.
//               Enqueue only when not full at the start of the cycle (no
//               bypass, no simultaneous enq/deq on a full FIFO).
// Ports       : clk_i, reset_i   - clock, synchronous active-high reset
//               v_i / ready_o    - write valid / not-full
//               data_i           - write data
//               v_o / data_o     - head valid / head data
//               yumi_i           - head consumed (only when v_o)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_stream_host_dispatch_fifo #(
    parameter int WIDTH_P = 32,
    parameter int ELS_P   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               v_o,
    output logic [WIDTH_P-1:0] data_o,
    input  logic               yumi_i
);
    localparam int PTR_W = (ELS_P > 1) ? $clog2(ELS_P) : 1;
    localparam int CNT_W = $clog2(ELS_P + 1);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(ELS_P - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(ELS_P);

    logic [WIDTH_P-1:0] r_mem [ELS_P];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_enq;
    logic w_deq;

    assign ready_o = (r_count != C_FULL);
    assign v_o     = (r_count != '0);
    assign data_o  = r_mem[r_rd_ptr];

    assign w_enq = v_i & ready_o;
    assign w_deq = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible when v_o is set.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule : mc_stream_host_dispatch_fifo
`default_nettype wire

// File: rtl/mc_stream_host_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : mc_stream_host_dispatch
// Description : Host-side stream front end for the manycore IO endpoint.
//               Decodes address-tagged host words onto buffered sink
//               channels, handles a fence command, records unmapped
//               addresses and gates the loader packet handshake on credits.
// Ports       : clk_i, reset_i                 - clock, sync active-high reset
//               stream_v_i/addr_i/data_i       - host word in
//               stream_yumi_o                  - host word consumed
//               chan_v_o/chan_data_o/chan_yumi_i - per-channel sink outputs
//               out_credits_i                  - endpoint available credits
//               gate_v_i/gate_ready_o          - loader side of packet gate
//               gate_v_o/gate_ready_i          - endpoint side of packet gate
//               fence_busy_o                   - fence in progress
//               err_count_o/err_addr_o         - unmapped word count / address
// Revision    : 1.0 - initial release
// ============================================================================
module mc_stream_host_dispatch
    import mc_stream_host_pkg::*;
#(
    parameter int          NUM_CHAN_P          = 2,
    parameter int          STREAM_ADDR_WIDTH_P = 32,
    parameter int          STREAM_DATA_WIDTH_P = 32,
    parameter int unsigned BASE_ADDR_P         = NBF_ADDR,
    parameter int unsigned STRIDE_P            = 32'h10,
    parameter int unsigned FENCE_ADDR_P        = FENCE_ADDR,
    parameter int          FIFO_ELS_P          = 2,
    parameter int          MAX_OUT_CREDITS_P   = 200,
    parameter int          CREDIT_RESERVE_P    = 1,
    parameter int          ERR_COUNT_WIDTH_P   = 16,
    localparam int         CREDIT_COUNTER_WIDTH_LP = safe_clog2(MAX_OUT_CREDITS_P + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic                                      stream_v_i,
    input  logic [STREAM_ADDR_WIDTH_P-1:0]            stream_addr_i,
    input  logic [STREAM_DATA_WIDTH_P-1:0]            stream_data_i,
    output logic                                      stream_yumi_o,

    output logic [NUM_CHAN_P-1:0]                     chan_v_o,
    output logic [NUM_CHAN_P*STREAM_DATA_WIDTH_P-1:0] chan_data_o,
    input  logic [NUM_CHAN_P-1:0]                     chan_yumi_i,

    input  logic [CREDIT_COUNTER_WIDTH_LP-1:0]        out_credits_i,
    input  logic                                      gate_v_i,
    output logic                                      gate_ready_o,
    output logic                                      gate_v_o,
    input  logic                                      gate_ready_i,

    output logic                                      fence_busy_o,
    output logic [ERR_COUNT_WIDTH_P-1:0]              err_count_o,
    output logic [STREAM_ADDR_WIDTH_P-1:0]            err_addr_o
);
    localparam logic [STREAM_ADDR_WIDTH_P-1:0] C_FENCE_ADDR =
        STREAM_ADDR_WIDTH_P'(FENCE_ADDR_P);
    localparam logic [CREDIT_COUNTER_WIDTH_LP-1:0] C_MAX_CRED =
        CREDIT_COUNTER_WIDTH_LP'(MAX_OUT_CREDITS_P);
    localparam logic [CREDIT_COUNTER_WIDTH_LP-1:0] C_RESERVE =
        CREDIT_COUNTER_WIDTH_LP'(CREDIT_RESERVE_P);

    fence_state_e r_state;
    fence_state_e w_state_next;

    logic [NUM_CHAN_P-1:0] w_chan_hit;
    logic [NUM_CHAN_P-1:0] w_fifo_ready;
    logic [NUM_CHAN_P-1:0] w_enq;
    logic                  w_fence_hit;
    logic                  w_stream_yumi;
    logic                  w_unmapped_take;
    logic                  w_gate_ok;

    logic [ERR_COUNT_WIDTH_P-1:0]   r_err_count;
    logic [STREAM_ADDR_WIDTH_P-1:0] r_err_addr;

    // ------------------------------------------------------------------
    // Address decode and per-channel buffers
    // ------------------------------------------------------------------
    assign w_fence_hit = (stream_addr_i == C_FENCE_ADDR);

    for (genvar k = 0; k < NUM_CHAN_P; k++) begin : g_chan
        localparam logic [STREAM_ADDR_WIDTH_P-1:0] C_CHAN_ADDR =
            STREAM_ADDR_WIDTH_P'(chan_addr(BASE_ADDR_P, STRIDE_P, k));

        assign w_chan_hit[k] = (stream_addr_i == C_CHAN_ADDR);

        mc_stream_host_dispatch_fifo #(
            .WIDTH_P (STREAM_DATA_WIDTH_P),
            .ELS_P   (FIFO_ELS_P)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (w_enq[k]),
            .ready_o (w_fifo_ready[k]),
            .data_i  (stream_data_i),
            .v_o     (chan_v_o[k]),
            .data_o  (chan_data_o[k*STREAM_DATA_WIDTH_P +: STREAM_DATA_WIDTH_P]),
            .yumi_i  (chan_yumi_i[k])
        );
    end

    // ------------------------------------------------------------------
    // Fence sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_stream_yumi   = 1'b0;
        w_enq           = '0;
        w_unmapped_take = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Reset suppresses every consume so nothing is lost into a
                // buffer that is being flushed.
                if (stream_v_i && !reset_i) begin
                    if (|w_chan_hit) begin
                        w_enq         = w_chan_hit & w_fifo_ready;
                        w_stream_yumi = |w_enq;
                    end else if (w_fence_hit) begin
                        w_stream_yumi = 1'b1;
                        w_state_next  = ST_DRAIN_FIFO;
                    end else begin
                        w_stream_yumi   = 1'b1;
                        w_unmapped_take = 1'b1;
                    end
                end
            end
            ST_DRAIN_FIFO: begin
                // Uses registered occupancy: a final yumi this cycle is only
                // seen as empty on the next cycle.
                if (~|chan_v_o) begin
                    w_state_next = ST_DRAIN_CRED;
                end
            end
            ST_DRAIN_CRED: begin
                if (out_credits_i == C_MAX_CRED) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign stream_yumi_o = w_stream_yumi;
    assign fence_busy_o  = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Unmapped-address capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else if (w_unmapped_take) begin
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
            r_err_addr <= stream_addr_i;
        end
    end

    assign err_count_o = r_err_count;
    assign err_addr_o  = r_err_addr;

    // ------------------------------------------------------------------
    // Credit gate: purely combinational, closed while waiting for credits
    // to return during a fence.
    // ------------------------------------------------------------------
    assign w_gate_ok    = (out_credits_i > C_RESERVE) && (r_state != ST_DRAIN_CRED);
    assign gate_v_o     = gate_v_i & w_gate_ok;
    assign gate_ready_o = gate_ready_i & w_gate_ok;

endmodule : mc_stream_host_dispatch
`default_nettype wire

// File: doc/mc_stream_host_dispatch.md
Name: mc_stream_host_dispatch

Overview:
Parametrised host-side stream front end for the manycore IO endpoint.
- Decodes an address-tagged host stream (AXI-Lite derived) onto num_chan_p buffered sink channels, e.g. NBF loader and MMIO.
- Gates the loader's outbound packet handshake against endpoint credits with a configurable reserve.
- Adds a fence command that stalls the host stream until all prior words are delivered and all network requests are acknowledged.
- Counts and records unmapped addresses instead of hanging on them.

Parameters:
num_chan_p, 2, number of sink channels (1..8)
stream_addr_width_p, 32, stream address width
stream_data_width_p, 32, stream data width
base_addr_p, 32'h10, address of channel 0
stride_p, 32'h10, address spacing between channels
fence_addr_p, 32'h100, fence command address; must not collide with any channel address
fifo_els_p, 2, per-channel buffer depth (>=2)
max_out_credits_p, 200, endpoint credit maximum
credit_reserve_p, 1, credits withheld; a packet is passed only if credits > credit_reserve_p
err_count_width_p, 16, unmapped-address counter width
credit_counter_width_lp, `BSG_SAFE_CLOG2(max_out_credits_p+1), derived

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
stream_v_i  in  1  host word valid
stream_addr_i  in  stream_addr_width_p  host word address
stream_data_i  in  stream_data_width_p  host word data
stream_yumi_o  out  1  host word consumed this cycle
chan_v_o  out  num_chan_p  per-channel valid
chan_data_o  out  num_chan_p*stream_data_width_p  per-channel data, channel k at slice k
chan_yumi_i  in  num_chan_p  per-channel consume (only when chan_v_o[k])
out_credits_i  in  credit_counter_width_lp  endpoint available credits
gate_v_i  in  1  loader packet valid
gate_ready_o  out  1  ready to loader
gate_v_o  out  1  packet valid to endpoint
gate_ready_i  in  1  endpoint ready
fence_busy_o  out  1  fence in progress
err_count_o  out  err_count_width_p  unmapped-word count, saturating
err_addr_o  out  stream_addr_width_p  address of most recent unmapped word

Behaviour:
- Decode is combinational on stream_addr_i:
  - chan k when addr == base_addr_p + k*stride_p, computed at stream_addr_width_p bits with wrap.
  - fence when addr == fence_addr_p.
  - otherwise unmapped.
- FSM states: IDLE, DRAIN_FIFO, DRAIN_CRED. Reset -> IDLE.
- In IDLE:
  - Channel word: stream_yumi_o = stream_v_i & ~full[k]. The word is enqueued into FIFO k the same cycle and appears on chan_v_o[k] the next cycle (1-cycle latency).
  - Unmapped word: stream_yumi_o = 1. err_count_o increments, holding at all-ones; err_addr_o <= stream_addr_i.
  - Fence word: stream_yumi_o = 1 and the FSM moves to DRAIN_FIFO. The fence data is ignored.
- DRAIN_FIFO:
  - stream_yumi_o = 0 for every address.
  - Gate still passes packets.
  - Move to DRAIN_CRED when all channel FIFOs are empty. The check is made on registered state; a yumi in the same cycle that empties the last entry counts on the following cycle.
- DRAIN_CRED:
  - stream_yumi_o = 0.
  - gate_v_o = 0 and gate_ready_o = 0.
  - Move to IDLE when out_credits_i == max_out_credits_p.
- fence_busy_o = (state != IDLE).
- Gate, combinational, no storage:
  - ok = (out_credits_i > credit_reserve_p) & (state != DRAIN_CRED).
  - gate_v_o = gate_v_i & ok; gate_ready_o = gate_ready_i & ok.
- FIFOs: an enqueue and a dequeue in the same cycle on a full FIFO is NOT allowed. Enqueue requires ~full at cycle start (no bypass).
- Reset values:
  - all FIFOs empty; chan_v_o = 0.
  - stream_yumi_o = 0 while reset_i.
  - err_count_o = 0, err_addr_o = 0, fence_busy_o = 0.
  - gate outputs follow inputs per the gate equations (state = IDLE).
- Reset mid-fence aborts the fence and returns to IDLE with FIFOs flushed.

Decomposition:
- Package mc_stream_host_pkg:
  - fence/state enum (IDLE, DRAIN_FIFO, DRAIN_CRED).
  - default address constants: NBF 32'h10, MMIO 32'h20, fence 32'h100.
  - chan_addr(k) decode function.
- Sub-module: per-channel FIFO as a generate array of bsg_fifo_1r1w_small (width stream_data_width_p, els fifo_els_p). Decode, FSM, error capture and credit gate stay in the top.

Test Plan:
1. Words to 0x10, 0x20, 0x10 with both chans ready -> chan0 gets d0 then d2, chan1 gets d1, each valid 1 cycle after its yumi; err_count = 0.
2. Chan0 held not ready; 3 words to 0x10 with fifo_els_p=2 -> first 2 yumied, third stalls. stream_yumi_o = 0 until chan0 yumi, then accepted the following cycle.
3. Word to 0x44 -> yumied immediately; err_count = 1, err_addr = 0x44. Force count to all-ones, send another unmapped word -> count stays all-ones.
4. Fence with chan1 holding 1 word and out_credits = 198:
   - DRAIN_FIFO until the chan1 yumi.
   - DRAIN_CRED with gate_v_o = 0 until credits = 200.
   - Then IDLE; a following 0x10 word is accepted.
5. credit_reserve_p=1, gate_v_i = 1, gate_ready_i = 1:
   - credits 2 -> gate_v_o = 1.
   - credits 1 -> gate_v_o = 0 and gate_ready_o = 0.
6. Assert reset_i during DRAIN_CRED with 1 word queued -> next cycle IDLE, chan_v_o = 0, fence_busy_o = 0, counters 0.
